// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   fwd_sel_e  : EX operand source select (register file, MEM ALU result, WB data)
//   hz_state_e : controller FSM state
//   REG_ZERO   : hard-wired zero register index (never a real producer)
//   fwd_pick() : MEM-over-WB forwarding priority
// Optional feature macro: HAZARD_FORWARD_EN (see hazard_ctrl.sv).
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_e;

  localparam int REG_ZERO = 0;
  localparam int NUM_SRC  = 2;  // rs1, rs2

  // The MEM result is younger than the WB result, so it wins when both match.
  function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline/decoder and the hazard controller.
//   ID slot info  : id_valid, id_insn_vld, id_rs*_addr/used, id_rd_addr, id_rd_wren, id_is_load
//   EX redirect   : ex_pc_sel
//   LSU handshake : mem_lsu_req, mem_lsu_ready
//   Controls out  : stall_*, flush_*, fwd_a_sel/fwd_b_sel, halt
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic              id_insn_vld;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_rd_wren;
  logic              id_is_load;
  logic              ex_pc_sel;
  logic              mem_lsu_req;
  logic              mem_lsu_ready;

  logic              stall_pc;
  logic              stall_if_id;
  logic              stall_id_ex;
  logic              stall_ex_mem;
  logic              stall_mem_wb;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              halt;

  modport master (
    output id_valid, id_insn_vld, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_wren, id_is_load, ex_pc_sel, mem_lsu_req, mem_lsu_ready,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, halt
  );

  modport slave (
    input  id_valid, id_insn_vld, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_wren, id_is_load, ex_pc_sel, mem_lsu_req, mem_lsu_ready,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, halt
  );

endinterface

// File: rtl/hazard_match.sv
// hazard_match: one source-vs-destination comparator.
//   addr/used : consumer source register and whether it is actually read
//   rd/wren   : producer destination and write enable
//   match     : producer result is needed by the consumer (x0 never matches)
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic              used,
  input  logic [REG_AW-1:0] rd,
  input  logic              wren,
  output logic              match
);

  assign match = used & wren & (rd != REG_AW'(REG_ZERO)) & (addr == rd);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage RV32I pipeline.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   hz (slave)     : decoder/ID info, EX redirect, LSU handshake in;
//                    stall/flush strobes, EX forwarding selects, halt out
// Keeps a shadow of register-use metadata for EX/MEM/WB that moves under the
// same stall/flush strobes it drives, so it always mirrors the real pipeline.
// Build option HAZARD_FORWARD_EN: forwarding on, only load-use stalls.
// Without it the fwd selects are tied to register file and any EX/MEM/WB
// producer of an ID source stalls the front end until it has written back.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input logic          i_clk,
  input logic          i_rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int NUM_STG = 3;  // shadow slots: [0]=EX [1]=MEM [2]=WB
`ifdef HAZARD_FORWARD_EN
  localparam int ID_STG = 1;   // MEM/WB producers are forwarded, only EX can block
`else
  localparam int ID_STG = NUM_STG;
`endif

  // Shadow state
  logic                            ex_valid;
  logic                            ex_illegal;
  logic [NUM_STG-1:0][REG_AW-1:0]  stg_rd;
  logic [NUM_STG-1:0]              stg_wren;
`ifdef HAZARD_FORWARD_EN
  logic                            ex_load;
  logic [NUM_SRC-1:0][REG_AW-1:0]  ex_rs;
  logic [NUM_SRC-1:0]              ex_used;
  logic [NUM_SRC-1:0][1:0]         ex_hit;  // [src][0=MEM,1=WB]
  fwd_sel_e                        fwd_a;
  fwd_sel_e                        fwd_b;
`endif

  hz_state_e                       state_q, state_d;

  logic [NUM_SRC-1:0][REG_AW-1:0]  id_rs;
  logic [NUM_SRC-1:0]              id_used;
  logic [NUM_SRC-1:0][ID_STG-1:0]  id_hit;

  logic data_hz, lsu_wait, ex_bad;
  logic stall_all, stall_front, flush_if, flush_ex, halt_w;

  // ID source comparators (bubbles never read anything)
  assign id_rs   = {hz.id_rs2_addr, hz.id_rs1_addr};
  assign id_used = {hz.id_rs2_used, hz.id_rs1_used} & {NUM_SRC{hz.id_valid}};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_id_src
    for (genvar k = 0; k < ID_STG; k++) begin : g_id_stg
      hazard_match #(.REG_AW(REG_AW)) u_match (
        .addr  (id_rs[s]),
        .used  (id_used[s]),
        .rd    (stg_rd[k]),
        .wren  (stg_wren[k]),
        .match (id_hit[s][k])
      );
    end
  end

`ifdef HAZARD_FORWARD_EN
  // Load data only exists after MEM, so an EX-slot load cannot be forwarded.
  assign data_hz = (|id_hit) & ex_load;

  // EX operand comparators against MEM and WB, decoded from shadow only.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_ex_src
    for (genvar k = 0; k < 2; k++) begin : g_ex_stg
      hazard_match #(.REG_AW(REG_AW)) u_match (
        .addr  (ex_rs[s]),
        .used  (ex_used[s]),
        .rd    (stg_rd[k+1]),
        .wren  (stg_wren[k+1]),
        .match (ex_hit[s][k])
      );
    end
  end

  assign fwd_a = fwd_pick(ex_hit[0][0], ex_hit[0][1]);
  assign fwd_b = fwd_pick(ex_hit[1][0], ex_hit[1][1]);
`else
  assign data_hz = |id_hit;
`endif

  assign lsu_wait = hz.mem_lsu_req & ~hz.mem_lsu_ready;
  assign ex_bad   = ex_valid & ex_illegal;

  // FSM next state and control decode
  always_comb begin
    state_d     = state_q;
    stall_all   = 1'b0;
    stall_front = 1'b0;
    flush_if    = 1'b0;
    flush_ex    = 1'b0;
    halt_w      = 1'b0;

    case (state_q)
      RUN:      if (lsu_wait) state_d = MEM_WAIT;
      MEM_WAIT: if (hz.mem_lsu_ready) state_d = RUN;
      HALT:     state_d = HALT;
      default:  state_d = RUN;
    endcase
    if ((state_q != HALT) && ex_bad) state_d = HALT;

    // halt is raised while the illegal op is in EX, one cycle before HALT registers
    if ((state_q == HALT) || ex_bad) begin
      halt_w    = 1'b1;
      stall_all = 1'b1;
    end else if (lsu_wait) begin
      // freezes EX too, so a pending redirect is replayed once the LSU is done
      stall_all = 1'b1;
    end else if (hz.ex_pc_sel) begin
      // the ID instruction is on the wrong path; its hazard is moot
      flush_if = 1'b1;
      flush_ex = 1'b1;
    end else if (data_hz) begin
      stall_front = 1'b1;
      flush_ex    = 1'b1;
    end
  end

  // Outputs forced quiet while reset is held, regardless of live inputs.
  always_comb begin
    hz.stall_pc     = 1'b0;
    hz.stall_if_id  = 1'b0;
    hz.stall_id_ex  = 1'b0;
    hz.stall_ex_mem = 1'b0;
    hz.stall_mem_wb = 1'b0;
    hz.flush_if_id  = 1'b0;
    hz.flush_id_ex  = 1'b0;
    hz.fwd_a_sel    = FWD_NONE;
    hz.fwd_b_sel    = FWD_NONE;
    hz.halt         = 1'b0;
    if (i_rst_n) begin
      hz.stall_pc     = stall_all | stall_front;
      hz.stall_if_id  = stall_all | stall_front;
      hz.stall_id_ex  = stall_all;
      hz.stall_ex_mem = stall_all;
      hz.stall_mem_wb = stall_all;
      hz.flush_if_id  = flush_if;
      hz.flush_id_ex  = flush_ex;
      hz.halt         = halt_w;
`ifdef HAZARD_FORWARD_EN
      hz.fwd_a_sel    = fwd_a;
      hz.fwd_b_sel    = fwd_b;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // Shadow pipeline; every stall strobe freezes all three slots together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
      stg_rd     <= '0;
      stg_wren   <= '0;
`ifdef HAZARD_FORWARD_EN
      ex_load    <= 1'b0;
      ex_rs      <= '0;
      ex_used    <= '0;
`endif
    end else if (!stall_all) begin
      stg_rd[0] <= hz.id_rd_addr;
      if (flush_ex) begin
        ex_valid    <= 1'b0;
        ex_illegal  <= 1'b0;
        stg_wren[0] <= 1'b0;
      end else begin
        ex_valid    <= hz.id_valid;
        ex_illegal  <= hz.id_valid & ~hz.id_insn_vld;
        stg_wren[0] <= hz.id_valid & hz.id_insn_vld & hz.id_rd_wren;
      end
`ifdef HAZARD_FORWARD_EN
      ex_rs   <= id_rs;
      ex_used <= flush_ex ? '0 : id_used;
      ex_load <= ~flush_ex & hz.id_is_load;
`endif
      stg_rd[2:1]   <= stg_rd[1:0];
      stg_wren[2:1] <= stg_wren[1:0];
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl.
// Expected control words are queued as each cycle's inputs are driven and
// popped at the following negedge. Expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5)) hz ();

  hazard_ctrl #(.REG_AW(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hz.slave)
  );

  typedef struct packed {
    logic       valid;
    logic       ivld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wren;
    logic       load;
  } instr_t;

  // {stall pc,if_id,id_ex,ex_mem,mem_wb, flush if_id,id_ex, fwd_a, fwd_b, halt}
  localparam logic [11:0] Z      = 12'b0;
  localparam logic [11:0] HZ     = {5'b11000, 2'b01, 5'b0};
  localparam logic [11:0] SA     = {5'b11111, 7'b0};
  localparam logic [11:0] HALTV  = {5'b11111, 6'b0, 1'b1};
  localparam logic [11:0] FL     = {5'b00000, 2'b11, 5'b0};
  localparam logic [11:0] FA_MEM = {7'b0, 2'b01, 3'b0};
  localparam logic [11:0] FA_WB  = {7'b0, 2'b10, 3'b0};
  localparam logic [11:0] FB_MEM = {9'b0, 2'b01, 1'b0};

  int n_cmp  = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];
  string       tag_q[$];

  instr_t BUB, ADD5, ADD6, LW5, ADD0, USE0, ILL, CONSB;

  function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic wren, input logic load);
    instr_t i;
    i = '0;
    i.valid = 1'b1; i.ivld = 1'b1;
    i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
    i.rd = rd; i.wren = wren; i.load = load;
    return i;
  endfunction

  function automatic logic [11:0] obs();
    return {hz.stall_pc, hz.stall_if_id, hz.stall_id_ex, hz.stall_ex_mem, hz.stall_mem_wb,
            hz.flush_if_id, hz.flush_id_ex, hz.fwd_a_sel, hz.fwd_b_sel, hz.halt};
  endfunction

  task automatic drive(input instr_t i, input logic pc, input logic req, input logic rdy);
    hz.id_valid      = i.valid;
    hz.id_insn_vld   = i.ivld;
    hz.id_rs1_addr   = i.rs1;
    hz.id_rs2_addr   = i.rs2;
    hz.id_rs1_used   = i.u1;
    hz.id_rs2_used   = i.u2;
    hz.id_rd_addr    = i.rd;
    hz.id_rd_wren    = i.wren;
    hz.id_is_load    = i.load;
    hz.ex_pc_sel     = pc;
    hz.mem_lsu_req   = req;
    hz.mem_lsu_ready = rdy;
  endtask

  task automatic push(input logic [11:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [11:0] o, e;
    string t;
    o = obs();
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %b expected none", o);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", t, o, e);
    end
  endtask

  // One pipeline cycle: drive after the edge, check at the negedge.
  task automatic step(input instr_t i, input logic pc, input logic req, input logic rdy,
                      input logic chk, input logic [11:0] e, input string tag);
    @(posedge clk); #1;
    drive(i, pc, req, rdy);
    if (chk) push(e, tag);
    @(negedge clk);
    if (chk) check_out();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(BUB, 1'b0, 1'b0, 1'b0, 1'b0, Z, "drain");
  endtask

  initial begin
    BUB   = '0;
    ADD5  = mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5,x1,x2
    ADD6  = mk(5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // add x6,x5,x3
    LW5   = mk(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);  // lw  x5,0(x1)
    ADD0  = mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);  // add x0,x1,x2
    USE0  = mk(5'd0, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);  // add x7,x0,x3
    CONSB = mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // add x6,x3,x5
    ILL   = '0;
    ILL.valid = 1'b1;

    // Reset held with noisy inputs: outputs stay quiet.
    drive(BUB, 1'b1, 1'b1, 1'b0);
    #2;
    push(Z, "rst_outs");
    check_out();
    @(negedge clk);
    drive(BUB, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(BUB, 0, 0, 0, 1, Z, "rst_first_run");

    // S1: back-to-back ALU dependency
    step(ADD5, 0, 0, 0, 1, Z, "s1_prod");
`ifdef HAZARD_FORWARD_EN
    step(ADD6, 0, 0, 0, 1, Z,      "s1_cons_nostall");
    step(BUB,  0, 0, 0, 1, FA_MEM, "s1_fwd_mem");
`else
    step(ADD6, 0, 0, 0, 1, HZ, "s1_raw_ex");
    step(ADD6, 0, 0, 0, 1, HZ, "s1_raw_mem");
    step(ADD6, 0, 0, 0, 1, HZ, "s1_raw_wb");
    step(ADD6, 0, 0, 0, 1, Z,  "s1_raw_release");
    step(BUB,  0, 0, 0, 1, Z,  "s1_fwd_tied");
`endif
    drain(3);

    // S2: load-use
    step(LW5,  0, 0, 0, 1, Z,  "s2_load");
    step(ADD6, 0, 0, 0, 1, HZ, "s2_lu_stall");
`ifdef HAZARD_FORWARD_EN
    step(ADD6, 0, 1, 1, 1, Z,     "s2_one_bubble");
    step(BUB,  0, 0, 0, 1, FA_WB, "s2_fwd_wb");
`else
    step(ADD6, 0, 1, 1, 1, HZ, "s2_lu_mem");
    step(ADD6, 0, 0, 0, 1, HZ, "s2_lu_wb");
    step(ADD6, 0, 0, 0, 1, Z,  "s2_release");
`endif
    drain(3);

    // S3: redirect in EX beats load-use hazard in ID
    step(LW5,  0, 0, 0, 1, Z,  "s3_load");
    step(ADD6, 1, 0, 0, 1, FL, "s3_br_over_hz");
    step(BUB,  0, 0, 0, 1, Z,  "s3_hz_discarded");
    drain(3);

    // S4: LSU wait for 3 cycles, shadow frozen
    step(ADD5, 0, 0, 0, 1, Z,  "s4_prod");
    step(BUB,  0, 0, 0, 1, Z,  "s4_gap");
    step(BUB,  0, 1, 0, 1, SA, "s4_wait1");
    step(BUB,  1, 1, 0, 1, SA, "s4_wait2_pcsel");
    step(BUB,  1, 1, 0, 1, SA, "s4_wait3_pcsel");
`ifdef HAZARD_FORWARD_EN
    step(ADD6, 0, 1, 1, 1, Z,     "s4_ready_resume");
    step(BUB,  0, 0, 0, 1, FA_WB, "s4_shadow_kept");
`else
    step(ADD6, 0, 1, 1, 1, HZ, "s4_ready_mem_hit");
    step(ADD6, 0, 0, 0, 1, HZ, "s4_wb_hit");
    step(ADD6, 0, 0, 0, 1, Z,  "s4_release");
`endif
    drain(3);

    // S5: x0 is never a hazard or forwarding source
    step(ADD0, 0, 0, 0, 1, Z, "s5_x0_prod");
    step(USE0, 0, 0, 0, 1, Z, "s5_x0_nostall");
    step(BUB,  0, 0, 0, 1, Z, "s5_x0_fwd");
    drain(3);

`ifdef HAZARD_FORWARD_EN
    // S7: MEM beats WB when both produce the source; rs2 path
    step(ADD5,  0, 0, 0, 1, Z,      "s7_prod_a");
    step(ADD5,  0, 0, 0, 1, Z,      "s7_prod_b");
    step(CONSB, 0, 0, 0, 1, Z,      "s7_cons");
    step(BUB,   0, 0, 0, 1, FB_MEM, "s7_fwd_b_mem_wins");
    drain(3);
`endif

    // S6: illegal instruction halts until reset
    step(ILL, 0, 0, 0, 1, Z,     "s6_ill_in_id");
    step(BUB, 0, 0, 0, 1, HALTV, "s6_halt_ex");
    step(BUB, 1, 0, 0, 1, HALTV, "s6_halt_hold");
    step(BUB, 1, 1, 0, 1, HALTV, "s6_halt_over_lsu");
    @(posedge clk); #1;
    rst_n = 1'b0;
    push(Z, "s6_rst_mid_halt");
    #1;
    check_out();
    @(negedge clk);
    drive(BUB, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(BUB,  0, 0, 0, 1, Z, "s6_post_rst_run");
    step(ADD5, 0, 0, 0, 1, Z, "s6_post_rst_issue");
    step(BUB,  0, 0, 0, 1, Z, "s6_post_rst_no_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It keeps a shadow copy of register-use metadata for the ID/EX/MEM/WB slots and generates per-stage stall/flush strobes. It also drives the EX-stage operand forwarding selects. It sits beside the decoder and consumes decoder outputs (write enable, write-back select, instruction valid), the EX-stage branch/jump decision and the LSU ready handshake.

## Interface
Parameters:
- `REG_AW`, default 5: register address width.

Ports:
- `i_clk`  in  1  core clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `id_valid`  in  1  ID slot holds a real instruction (not a bubble).
- `id_insn_vld`  in  1  decoder legality flag for the ID instruction.
- `id_rs1_addr`, `id_rs2_addr`  in  REG_AW  source registers of the ID instruction.
- `id_rs1_used`, `id_rs2_used`  in  1  the ID instruction reads that source.
- `id_rd_addr`  in  REG_AW  destination register.
- `id_rd_wren`  in  1  the ID instruction writes the register file.
- `id_is_load`  in  1  write-back select is load data.
- `ex_pc_sel`  in  1  branch taken or jump, resolved in EX.
- `mem_lsu_req`  in  1  the MEM instruction accesses the LSU.
- `mem_lsu_ready`  in  1  the LSU completes the access this cycle.
- `stall_pc`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem`, `stall_mem_wb`  out  1  hold the named register.
- `flush_if_id`, `flush_id_ex`  out  1  load a bubble into the named register.
- `fwd_a_sel`, `fwd_b_sel`  out  2  EX operand source: 00 register file/pipeline value, 01 MEM-stage ALU result, 10 WB-stage write data.
- `halt`  out  1  an illegal instruction reached EX.

## Operation
- Shadow registers per slot:
  - EX: valid, illegal, rs1, rs2, rs1_used, rs2_used, rd, wren, load.
  - MEM: rd, wren.
  - WB: rd, wren.
- The shadow advances in lockstep with the pipeline under the same stall/flush outputs. A flushed slot loads valid=0 and wren=0. A stalled slot holds its contents.
- A register-address match counts only if rd≠0, wren=1 and the source is used.
- FSM states: RUN, MEM_WAIT, HALT.
  - RUN→MEM_WAIT when mem_lsu_req=1 and mem_lsu_ready=0.
  - MEM_WAIT→RUN on mem_lsu_ready=1.
  - Any state except HALT→HALT when the EX shadow has valid=1 and illegal=1.
  - HALT is left only by reset.
- Priority, highest first:
  1. HALT: all stalls=1, flushes=0, halt=1.
  2. LSU wait (mem_lsu_req & !mem_lsu_ready): all five stalls=1, flushes=0. A pending ex_pc_sel is deferred because the EX instruction is held.
  3. ex_pc_sel=1: flush_if_id=1, flush_id_ex=1, no stalls. This overrides a simultaneous data-hazard stall.
  4. Data hazard on the ID instruction: stall_pc=1, stall_if_id=1, flush_id_ex=1 (insert a bubble).
- Forwarding for the EX instruction:
  - Per operand, a MEM match gives 01.
  - Otherwise a WB match gives 10.
  - Otherwise 00.
  - The MEM match wins when both stages match.
- Reset values:
  - All outputs 0.
  - Shadow cleared (valid=0, wren=0).
  - FSM in RUN.

## Timing
- Stall, flush and halt outputs are combinational from current inputs plus registered shadow/FSM state; they are valid in the same cycle.
- fwd_*_sel is decoded only from registered shadow, so it is stable for the whole EX cycle.
- Load-use with FORWARD_EN: exactly 1 bubble, and the consumer then sees FWD_WB.
- halt asserts the cycle the illegal instruction sits in EX. The FSM registers HALT at the next edge.
- Reset asserted mid-stall or in HALT clears everything asynchronously. The first cycle after deassertion is RUN with no stalls.

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - Forwarding active.
  - Data hazard = the ID source matches an EX-slot load only.
- Not defined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - Data hazard = the ID source matches any of the EX, MEM or WB slots (load or not).
  - A back-to-back dependency stalls 3 cycles.

## Structure
- Package `hazard_pkg`:
  - `fwd_sel_e` (FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10).
  - `hz_state_e` (RUN, MEM_WAIT, HALT).
  - `REG_ZERO` constant.
- Sub-module `hazard_match`: combinational source-vs-destination comparator (addr, used, rd, wren → match, with the rd≠0 check). It is instantiated once per source/stage pair.

## Test plan
- FORWARD_EN on: `add x5,x1,x2` then `add x6,x5,x3` → no stall; fwd_a_sel=01 during the consumer's EX cycle.
- `lw x5,0(x1)` then `add x6,x5,x3` → stall_pc=stall_if_id=flush_id_ex=1 for exactly 1 cycle, then fwd_a_sel=10.
- Taken branch in EX in the same cycle as a load-use hazard in ID → flush_if_id=flush_id_ex=1, stall_pc=0; the hazard is discarded.
- mem_lsu_req=1 with mem_lsu_ready=0 for 3 cycles → all five stalls=1 for 3 cycles, flushes=0, shadow unchanged; normal flow resumes in the cycle after ready.
- Producer with rd=x0 followed by a consumer of x0 → no stall, fwd=00. Without FORWARD_EN, the x5 dependency from scenario 1 → 3 stall cycles.
- Illegal instruction (id_valid=1, id_insn_vld=0) enters EX → halt=1 and stays asserted with all stalls=1; asserting i_rst_n=0 mid-halt clears all outputs immediately.
